// File: rtl/host_cmd_sequencer.sv
// Host command sequencer: collects length-prefixed frames from the UART, runs them
// through the command decoder, applies the decoded command and returns one status byte.
module host_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_LEN        = 128
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [1023:0] dec_input_data,
    output logic          dec_start,
    input  logic          dec_done,
    input  logic          dec_error,
    input  logic [15:0]   dec_cmd_select,
    input  logic [255:0]  dec_output_data,
    output logic          encrypt_en,
    output logic          yaw_req,
    output logic [47:0]   yaw_target,
    input  logic          yaw_ack,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic [7:0]    err_count
);

    localparam int NUM_LANES = 128;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ST_ENC_OFF   = 8'hA1;
    localparam logic [7:0] ST_ENC_ON    = 8'hA2;
    localparam logic [7:0] ST_YAW_OK    = 8'hA3;
    localparam logic [7:0] ST_BAD_LEN   = 8'hE1;
    localparam logic [7:0] ST_DEC_ERR   = 8'hE2;
    localparam logic [7:0] ST_BAD_CMD   = 8'hE3;
    localparam logic [7:0] ST_TMO_RX    = 8'hE4;
    localparam logic [7:0] ST_TMO_DEC   = 8'hE5;
    localparam logic [7:0] ST_TMO_YAW   = 8'hE6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DISPATCH,
        S_YAW_WAIT,
        S_RESP
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 len_q, len_d;
    logic [7:0]                 idx_q, idx_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [NUM_LANES-1:0][7:0]  buf_q, buf_d;
    logic                       buf_clr, buf_wr;
    logic                       dec_start_q, dec_start_d;
    logic                       encrypt_en_q, encrypt_en_d;
    logic                       yaw_req_q, yaw_req_d;
    logic [47:0]                yaw_target_q, yaw_target_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 err_count_q, err_count_d;
    logic                       resp_go;
    logic [7:0]                 status_sel;
    logic                       timed_out;

    // Only the low 48 bits of the decoded argument carry a yaw target.
    logic unused_arg_bits;
    assign unused_arg_bits = ^dec_output_data[255:48];

    assign timed_out = (timer_q == TIMER_LAST);

    // Frame buffer lanes: cleared when a new frame starts, one lane written per accepted byte.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign buf_d[gi] = buf_clr ? 8'h00
                             : ((buf_wr && (idx_q == 8'(gi))) ? rx_data : buf_q[gi]);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        buf_clr      = 1'b0;
        buf_wr       = 1'b0;
        dec_start_d  = 1'b0;
        encrypt_en_d = encrypt_en_q;
        yaw_req_d    = yaw_req_q;
        yaw_target_d = yaw_target_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        err_count_d  = err_count_q;
        resp_go      = 1'b0;
        status_sel   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (int'(rx_data) > MAX_LEN)) begin
                        resp_go    = 1'b1;
                        status_sel = ST_BAD_LEN;
                    end else begin
                        len_d   = rx_data;
                        idx_d   = 8'd0;
                        timer_d = '0;
                        buf_clr = 1'b1;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    buf_wr  = 1'b1;
                    idx_d   = idx_q + 8'd1;
                    timer_d = '0;
                    if ((idx_q + 8'd1) == len_q) begin
                        state_d = S_START;
                    end
                end else if (timed_out) begin
                    resp_go    = 1'b1;
                    status_sel = ST_TMO_RX;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_START: begin
                // Registered pulse: lands one cycle after START, two after the last byte.
                dec_start_d = 1'b1;
                timer_d     = '0;
                state_d     = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!dec_done) begin
                    timer_d = '0;
                    state_d = S_WAIT_HIGH;
                end else if (timed_out) begin
                    resp_go    = 1'b1;
                    status_sel = ST_TMO_DEC;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (dec_done) begin
                    state_d = S_DISPATCH;
                end else if (timed_out) begin
                    resp_go    = 1'b1;
                    status_sel = ST_TMO_DEC;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DISPATCH: begin
                if (dec_error || (dec_cmd_select == 16'hFFFF)) begin
                    resp_go    = 1'b1;
                    status_sel = ST_DEC_ERR;
                end else begin
                    case (dec_cmd_select)
                        16'h0001: begin
                            encrypt_en_d = 1'b0;
                            resp_go      = 1'b1;
                            status_sel   = ST_ENC_OFF;
                        end
                        16'h0002: begin
                            encrypt_en_d = 1'b1;
                            resp_go      = 1'b1;
                            status_sel   = ST_ENC_ON;
                        end
                        16'h0003: begin
                            yaw_target_d = dec_output_data[47:0];
                            yaw_req_d    = 1'b1;
                            timer_d      = '0;
                            state_d      = S_YAW_WAIT;
                        end
                        default: begin
                            resp_go    = 1'b1;
                            status_sel = ST_BAD_CMD;
                        end
                    endcase
                end
            end
            S_YAW_WAIT: begin
                // An ack arriving on the timeout cycle still wins.
                if (yaw_ack) begin
                    yaw_req_d  = 1'b0;
                    resp_go    = 1'b1;
                    status_sel = ST_YAW_OK;
                end else if (timed_out) begin
                    yaw_req_d  = 1'b0;
                    resp_go    = 1'b1;
                    status_sel = ST_TMO_YAW;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_go) begin
            state_d    = S_RESP;
            tx_data_d  = status_sel;
            tx_valid_d = 1'b1;
            if ((status_sel[7:4] == 4'hE) && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            timer_q      <= '0;
            buf_q        <= '0;
            dec_start_q  <= 1'b0;
            encrypt_en_q <= 1'b0;
            yaw_req_q    <= 1'b0;
            yaw_target_q <= 48'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            buf_q        <= buf_d;
            dec_start_q  <= dec_start_d;
            encrypt_en_q <= encrypt_en_d;
            yaw_req_q    <= yaw_req_d;
            yaw_target_q <= yaw_target_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dec_input_data = buf_q;
    assign dec_start      = dec_start_q;
    assign encrypt_en     = encrypt_en_q;
    assign yaw_req        = yaw_req_q;
    assign yaw_target     = yaw_target_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign busy           = busy_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Bench for host_cmd_sequencer: directed scenarios plus randomized frames checked against
// a command-level model of status, encryption bit, error count and decoder frame image.
module tb_host_cmd_sequencer;

    localparam int TMO  = 40;
    localparam int MAXL = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [1023:0] dec_input_data;
    logic          dec_start;
    logic          dec_done = 1'b1;
    logic          dec_error = 1'b0;
    logic [15:0]   dec_cmd_select = 16'h0;
    logic [255:0]  dec_output_data = '0;
    logic          encrypt_en;
    logic          yaw_req;
    logic [47:0]   yaw_target;
    logic          yaw_ack = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic [7:0]    err_count;

    host_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(MAXL)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .dec_input_data(dec_input_data), .dec_start(dec_start), .dec_done(dec_done),
        .dec_error(dec_error), .dec_cmd_select(dec_cmd_select), .dec_output_data(dec_output_data),
        .encrypt_en(encrypt_en), .yaw_req(yaw_req), .yaw_target(yaw_target), .yaw_ack(yaw_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic       m_enc = 1'b0;
    logic [7:0] m_err = 8'h00;
    logic [7:0] payload[$];

    // Decoder stub controls and observations
    bit            stub_ignore = 0;
    int            stub_low_dly = 0;
    int            stub_busy_dly = 2;
    logic          stub_err = 1'b0;
    logic [15:0]   stub_cmd = 16'h0;
    logic [255:0]  stub_out = '0;
    int            start_count = 0;
    int            start_cyc = 0;
    int            stable_viol = 0;
    int            last_drive_cyc = 0;
    logic [1023:0] captured = '0;

    always @(negedge clk) begin
        if (dec_start === 1'b1) begin
            start_count <= start_count + 1;
            start_cyc   <= cyc;
            captured    <= dec_input_data;
        end
    end

    initial begin : decoder_stub
        logic [1023:0] snap;
        forever begin
            @(negedge clk);
            if (dec_start === 1'b1 && !stub_ignore) begin
                snap = dec_input_data;
                repeat (stub_low_dly) @(negedge clk);
                dec_done = 1'b0;
                repeat (stub_busy_dly) @(negedge clk);
                if (dec_input_data !== snap) stable_viol++;
                dec_error       = stub_err;
                dec_cmd_select  = stub_cmd;
                dec_output_data = stub_out;
                dec_done        = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [7:0] model_status(input logic err, input logic [15:0] cmd, input bit ack);
        if (err || cmd == 16'hFFFF) return 8'hE2;
        if (cmd == 16'h0001) return 8'hA1;
        if (cmd == 16'h0002) return 8'hA2;
        if (cmd == 16'h0003) return ack ? 8'hA3 : 8'hE6;
        return 8'hE3;
    endfunction

    task automatic model_apply(input logic [7:0] st);
        if (st == 8'hA1) m_enc = 1'b0;
        if (st == 8'hA2) m_enc = 1'b1;
        if (st >= 8'hE1 && st <= 8'hE6 && m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    function automatic logic [1023:0] frame_image();
        logic [1023:0] img;
        img = '0;
        foreach (payload[k]) img[8*k +: 8] = payload[k];
        return img;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        last_drive_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output bit ok, output logic [7:0] data);
        ok = 0;
        data = 8'h00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                ok = 1;
                data = tx_data;
                break;
            end
        end
    endtask

    task automatic accept_tx(input int hold);
        repeat (hold) @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    // Sends length + payload, services yaw (yaw_dly < 0 withholds the ack), waits for status.
    task automatic run_frame(input int yaw_dly, output bit got_tx, output logic [7:0] st,
                             output bit got_yaw, output logic [47:0] tgt, output int yaw_cyc);
        send_byte(8'(payload.size()));
        foreach (payload[k]) send_byte(payload[k]);
        got_yaw = 0;
        tgt = '0;
        yaw_cyc = 0;
        if (stub_cmd == 16'h0003 && !stub_err) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (yaw_req === 1'b1) begin
                    got_yaw = 1;
                    tgt = yaw_target;
                    yaw_cyc = cyc;
                    break;
                end
            end
            if (got_yaw && yaw_dly >= 0) begin
                repeat (yaw_dly) @(negedge clk);
                yaw_ack = 1'b1;
                @(negedge clk);
                yaw_ack = 1'b0;
            end
        end
        wait_tx(3 * TMO + 200, got_tx, st);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dec_start, encrypt_en, yaw_req, tx_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {dec_start, encrypt_en, yaw_req, tx_valid, busy});
        end
        n_checks++;
        if ({err_count, tx_data, yaw_target} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {err_count, tx_data, yaw_target});
        end
        n_checks++;
        if (dec_input_data !== '0) begin
            n_fail++;
            $display("FAIL reset_frame: dec_input_data not zero");
        end
        reset_n = 1'b1;
        m_enc = 1'b0;
        m_err = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_encrypt_on();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc, s0;
        payload = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
        stub_err = 0; stub_cmd = 16'h0002; stub_out = '0;
        stub_low_dly = 1; stub_busy_dly = 3;
        s0 = start_count;
        run_frame(0, ok, st, gy, tg, yc);
        model_apply(8'hA2);
        n_checks++;
        if (!ok || st !== 8'hA2) begin
            n_fail++; $display("FAIL encrypt_status: got %h (valid=%0d) required a2", st, ok);
        end
        n_checks++;
        if (start_count - s0 !== 1) begin
            n_fail++; $display("FAIL encrypt_start_pulses: got %0d required 1", start_count - s0);
        end
        n_checks++;
        if (start_cyc - last_drive_cyc !== 2) begin
            n_fail++; $display("FAIL start_latency: got %0d required 2", start_cyc - last_drive_cyc);
        end
        n_checks++;
        if (captured !== frame_image()) begin
            n_fail++; $display("FAIL encrypt_frame: got %h required %h", captured[79:0], frame_image() & 1024'hFFFFFFFFFFFFFFFFFFFF);
        end
        n_checks++;
        if (encrypt_en !== m_enc || err_count !== m_err) begin
            n_fail++; $display("FAIL encrypt_state: got enc=%b err=%0d required enc=%b err=%0d", encrypt_en, err_count, m_enc, m_err);
        end
        accept_tx(0);
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL encrypt_handshake: got tx_valid=%b busy=%b required 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_yaw();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc;
        payload = '{8'h03, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        stub_err = 0; stub_cmd = 16'h0003;
        stub_out = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'hABCD, 48'h112233445566};
        run_frame(3, ok, st, gy, tg, yc);
        model_apply(8'hA3);
        n_checks++;
        if (!gy || tg !== 48'h112233445566) begin
            n_fail++; $display("FAIL yaw_target: got %h (req seen=%0d) required 112233445566", tg, gy);
        end
        n_checks++;
        if (!ok || st !== 8'hA3 || yaw_req !== 1'b0) begin
            n_fail++; $display("FAIL yaw_status: got %h yaw_req=%b required a3 yaw_req=0", st, yaw_req);
        end
        n_checks++;
        if (encrypt_en !== m_enc) begin
            n_fail++; $display("FAIL yaw_encrypt: got %b required %b", encrypt_en, m_enc);
        end
        accept_tx(1);
    endtask

    task automatic test_dec_error();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc;
        payload = '{8'h07, 8'h08, 8'h09};
        stub_err = 1; stub_cmd = 16'hFFFF;
        run_frame(0, ok, st, gy, tg, yc);
        model_apply(8'hE2);
        n_checks++;
        if (!ok || st !== 8'hE2) begin
            n_fail++; $display("FAIL dec_error_status: got %h required e2", st);
        end
        n_checks++;
        if (err_count !== m_err || encrypt_en !== m_enc) begin
            n_fail++; $display("FAIL dec_error_state: got err=%0d enc=%b required err=%0d enc=%b", err_count, encrypt_en, m_err, m_enc);
        end
        accept_tx(0);
        stub_err = 0;
    endtask

    task automatic test_bad_length();
        bit ok; logic [7:0] st; int s0;
        logic [7:0] lens[2];
        lens = '{8'h00, 8'h81};
        s0 = start_count;
        foreach (lens[i]) begin
            send_byte(lens[i]);
            wait_tx(10, ok, st);
            model_apply(8'hE1);
            n_checks++;
            if (!ok || st !== 8'hE1) begin
                n_fail++; $display("FAIL bad_length_%h: got %h required e1", lens[i], st);
            end
            accept_tx(0);
        end
        n_checks++;
        if (err_count !== m_err || start_count !== s0) begin
            n_fail++; $display("FAIL bad_length_state: got err=%0d starts=%0d required err=%0d starts=%0d", err_count, start_count - s0, m_err, 0);
        end
    endtask

    task automatic test_max_len();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc;
        payload = {};
        for (int k = 0; k < MAXL; k++) payload.push_back(8'($urandom()));
        stub_err = 0; stub_cmd = 16'h0001;
        run_frame(0, ok, st, gy, tg, yc);
        model_apply(8'hA1);
        n_checks++;
        if (!ok || st !== 8'hA1 || encrypt_en !== m_enc) begin
            n_fail++; $display("FAIL max_len_status: got %h enc=%b required a1 enc=%b", st, encrypt_en, m_enc);
        end
        n_checks++;
        if (captured !== frame_image()) begin
            n_fail++; $display("FAIL max_len_frame: got top byte %h required %h", captured[1023:1016], payload[MAXL-1]);
        end
        accept_tx(0);
    endtask

    task automatic test_collect_timeout();
        bit ok; logic [7:0] st; int s0, dt;
        s0 = start_count;
        send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_tx(TMO + 20, ok, st);
        dt = cyc - last_drive_cyc;
        model_apply(8'hE4);
        n_checks++;
        if (!ok || st !== 8'hE4) begin
            n_fail++; $display("FAIL collect_timeout_status: got %h required e4", st);
        end
        n_checks++;
        if (dt < TMO || dt > TMO + 2 || start_count !== s0) begin
            n_fail++; $display("FAIL collect_timeout_time: got %0d cycles starts=%0d required %0d..%0d starts=0", dt, start_count - s0, TMO, TMO + 2);
        end
        n_checks++;
        if (err_count !== m_err) begin
            n_fail++; $display("FAIL collect_timeout_errcnt: got %0d required %0d", err_count, m_err);
        end
        accept_tx(0);
    endtask

    task automatic test_yaw_timeout();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc, dt;
        payload = '{8'h03, 8'h01};
        stub_err = 0; stub_cmd = 16'h0003; stub_out = 256'h0000_0000_0000_0000_0000_DEAD_BEEF_0042;
        run_frame(-1, ok, st, gy, tg, yc);
        dt = cyc - yc;
        model_apply(model_status(1'b0, 16'h0003, 0));
        n_checks++;
        if (!ok || st !== 8'hE6 || yaw_req !== 1'b0) begin
            n_fail++; $display("FAIL yaw_timeout_status: got %h yaw_req=%b required e6 yaw_req=0", st, yaw_req);
        end
        n_checks++;
        if (!gy || dt < TMO || dt > TMO + 2) begin
            n_fail++; $display("FAIL yaw_timeout_time: got %0d cycles required %0d..%0d", dt, TMO, TMO + 2);
        end
        n_checks++;
        if (err_count !== m_err) begin
            n_fail++; $display("FAIL yaw_timeout_errcnt: got %0d required %0d", err_count, m_err);
        end
        accept_tx(0);
    endtask

    task automatic test_decoder_timeout();
        bit ok, gy; logic [7:0] st; logic [47:0] tg; int yc;
        payload = '{8'h02};
        stub_ignore = 1; stub_cmd = 16'h0002;
        run_frame(0, ok, st, gy, tg, yc);
        model_apply(8'hE5);
        n_checks++;
        if (!ok || st !== 8'hE5 || err_count !== m_err || encrypt_en !== m_enc) begin
            n_fail++; $display("FAIL decoder_timeout: got %h err=%0d enc=%b required e5 err=%0d enc=%b", st, err_count, encrypt_en, m_err, m_enc);
        end
        accept_tx(0);
        stub_ignore = 0;
    endtask

    task automatic test_dropped_bytes();
        bit ok; logic [7:0] st;
        payload = '{8'h44, 8'h55};
        stub_err = 0; stub_cmd = 16'h0001; stub_low_dly = 0; stub_busy_dly = 14;
        send_byte(8'h02); send_byte(8'h44); send_byte(8'h55);
        send_byte(8'h03); send_byte(8'h99); send_byte(8'h77);
        wait_tx(3 * TMO, ok, st);
        model_apply(8'hA1);
        n_checks++;
        if (!ok || st !== 8'hA1 || captured !== frame_image()) begin
            n_fail++; $display("FAIL dropped_in_decode: got %h frame_lo=%h required a1 frame_lo=5544", st, captured[15:0]);
        end
        send_byte(8'h05); send_byte(8'h06);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
            n_fail++; $display("FAIL dropped_in_resp: got tx_valid=%b data=%h required 1 a1", tx_valid, tx_data);
        end
        accept_tx(0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL dropped_idle: got busy=%b tx_valid=%b required 0 0", busy, tx_valid);
        end
        stub_busy_dly = 2;
    endtask

    task automatic test_tx_backpressure();
        bit ok; logic [7:0] st;
        send_byte(8'hC0);
        wait_tx(10, ok, st);
        model_apply(8'hE1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hE1) begin
                n_fail++; $display("FAIL backpressure_hold_%0d: got tx_valid=%b data=%h required 1 e1", i, tx_valid, tx_data);
            end
        end
        accept_tx(0);
        n_checks++;
        if (tx_valid !== 1'b0 || err_count !== m_err) begin
            n_fail++; $display("FAIL backpressure_release: got tx_valid=%b err=%0d required 0 %0d", tx_valid, err_count, m_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; logic [7:0] st; int seen;
        send_byte(8'h06); send_byte(8'hAA); send_byte(8'hBB);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({dec_start, encrypt_en, yaw_req, tx_valid, busy, err_count} !== 13'b0 || dec_input_data !== '0) begin
            n_fail++; $display("FAIL reset_async: got ctrl=%b err=%0d frame_lo=%h required all 0", {dec_start, encrypt_en, yaw_req, tx_valid, busy}, err_count, dec_input_data[15:0]);
        end
        m_enc = 1'b0;
        m_err = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < TMO + 10; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_no_status: got %0d active cycles required 0", seen);
        end
        send_byte(8'h00);
        wait_tx(10, ok, st);
        model_apply(8'hE1);
        n_checks++;
        if (!ok || st !== 8'hE1 || err_count !== m_err) begin
            n_fail++; $display("FAIL reset_recover: got %h err=%0d required e1 err=%0d", st, err_count, m_err);
        end
        accept_tx(0);
    endtask

    task automatic test_random_frames();
        bit ok, gy; logic [7:0] st, exp_st; logic [47:0] tg; int yc, s0, kind;
        logic [15:0] cmds[5];
        cmds = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 16'h0000};
        for (int n = 0; n < 25; n++) begin
            kind = $urandom_range(0, 9);
            s0 = start_count;
            if (kind == 0) begin
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
                wait_tx(10, ok, st);
                exp_st = 8'hE1;
            end else begin
                payload = {};
                for (int k = 0; k < $urandom_range(1, 24); k++) payload.push_back(8'($urandom()));
                stub_err = ($urandom_range(0, 7) == 0);
                stub_cmd = cmds[$urandom_range(0, 4)];
                if (stub_cmd == 16'h0000) stub_cmd = 16'($urandom_range(4, 16'hFFFE));
                stub_out = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                stub_low_dly = $urandom_range(0, 3);
                stub_busy_dly = $urandom_range(1, 6);
                run_frame($urandom_range(0, TMO / 2), ok, st, gy, tg, yc);
                exp_st = model_status(stub_err, stub_cmd, 1);
                n_checks++;
                if (start_count - s0 !== 1 || captured !== frame_image() || stable_viol !== 0) begin
                    n_fail++; $display("FAIL rand_%0d_frame: starts=%0d frame_lo=%h unstable=%0d required 1 %h 0", n, start_count - s0, captured[63:0], stable_viol, frame_image() & 1024'hFFFFFFFFFFFFFFFF);
                end
                if (exp_st == 8'hA3) begin
                    n_checks++;
                    if (!gy || tg !== stub_out[47:0]) begin
                        n_fail++; $display("FAIL rand_%0d_yaw_target: got %h required %h", n, tg, stub_out[47:0]);
                    end
                end
            end
            model_apply(exp_st);
            n_checks++;
            if (!ok || st !== exp_st) begin
                n_fail++; $display("FAIL rand_%0d_status: got %h (valid=%0d) required %h", n, st, ok, exp_st);
            end
            n_checks++;
            if (encrypt_en !== m_enc || err_count !== m_err) begin
                n_fail++; $display("FAIL rand_%0d_state: got enc=%b err=%0d required enc=%b err=%0d", n, encrypt_en, err_count, m_enc, m_err);
            end
            accept_tx($urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_on();
        test_yaw();
        test_dec_error();
        test_bad_length();
        test_max_len();
        test_collect_timeout();
        test_yaw_timeout();
        test_decoder_timeout();
        test_dropped_bytes();
        test_tx_backpressure();
        test_encrypt_on();
        test_reset_mid_frame();
        test_random_frames();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_cmd_sequencer.md
HOST_CMD_SEQUENCER -- requirements
Module: host_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles spent in any wait state before abort.
REQ-002 SHALL have parameter MAX_LEN, default 128, max frame payload bytes (1024-bit decoder input).
REQ-003 Ports SHALL be:
clk  in  1  single clock, all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
rx_data  in  8  byte from host UART receiver.
rx_valid  in  1  one-cycle strobe, rx_data valid.
dec_input_data  out  1024  frame to command decoder, byte k at bits [8k+7:8k].
dec_start  out  1  one-cycle start pulse to decoder.
dec_done  in  1  decoder idle/done (high when idle, low while busy).
dec_error  in  1  decoder format error.
dec_cmd_select  in  16  decoded command code.
dec_output_data  in  256  decoded argument.
encrypt_en  out  1  encryption enable configuration bit.
yaw_req  out  1  level request to yaw reader, held until yaw_ack.
yaw_target  out  48  target device id for yaw read.
yaw_ack  in  1  one-cycle yaw reader acknowledge.
tx_data  out  8  status byte to host UART transmitter.
tx_valid  out  1  status byte valid, held until tx_ready.
tx_ready  in  1  transmitter accepts when tx_valid & tx_ready.
busy  out  1  high in every state except IDLE.
err_count  out  8  saturating count of failed frames.

Function
REQ-004 FSM states SHALL be IDLE, COLLECT, START, WAIT_LOW, WAIT_HIGH, DISPATCH, YAW_WAIT, RESP.
REQ-005 IDLE: on rx_valid, byte SHALL be length L; L=0 or L>MAX_LEN -> RESP with status 8'hE1; else clear buffer to zero, byte index to 0, go COLLECT.
REQ-006 COLLECT: each rx_valid SHALL write rx_data to byte index, increment index; after L-th byte go START next cycle.
REQ-007 rx_valid in any state other than IDLE/COLLECT SHALL be dropped, no state change.
REQ-008 START: dec_start SHALL be high exactly one cycle with dec_input_data stable; then WAIT_LOW.
REQ-009 dec_input_data SHALL remain stable from START until DISPATCH.
REQ-010 WAIT_LOW: go WAIT_HIGH on dec_done==0; WAIT_HIGH: go DISPATCH on dec_done==1.
REQ-011 DISPATCH (one cycle) SHALL act on dec_error/dec_cmd_select sampled this cycle: dec_error=1 or 16'hFFFF -> status 8'hE2; 16'h1 -> encrypt_en<=0, status 8'hA1; 16'h2 -> encrypt_en<=1, status 8'hA2; 16'h3 -> yaw_target<=dec_output_data[47:0], yaw_req<=1, YAW_WAIT; any other -> status 8'hE3.
REQ-012 YAW_WAIT: on yaw_ack, yaw_req<=0, status 8'hA3, RESP.
REQ-013 Timeout counter SHALL clear on entry to COLLECT, WAIT_LOW, WAIT_HIGH, YAW_WAIT, and on each accepted byte in COLLECT; reaching TIMEOUT_CYCLES SHALL abort to RESP with status 8'hE4 (collect), 8'hE5 (decoder), 8'hE6 (yaw, yaw_req<=0).
REQ-014 Statuses 8'hE1-8'hE6 SHALL increment err_count, saturating at 8'hFF.
REQ-015 RESP: tx_valid=1 with tx_data=status until tx_ready; on handshake tx_valid<=0, go IDLE.
REQ-016 Bytes arriving during RESP/YAW_WAIT SHALL be lost; host retransmits on missing status.
REQ-017 Frame latency last byte -> dec_start SHALL be 2 cycles.
REQ-018 encrypt_en SHALL change only in DISPATCH.
REQ-019 yaw_ack in same cycle as timeout SHALL take the ack (status 8'hA3).

Reset
REQ-020 reset_n low SHALL asynchronously force IDLE, all outputs 0 (encrypt_en=0, err_count=0, dec_input_data=0), counters 0.
REQ-021 Reset mid-frame SHALL discard partial frame; no status byte sent.

Verification
REQ-022 Bytes 09,01,FF*6,01,01 -> one dec_start, cmd 16'h2 -> encrypt_en=1, tx_data=8'hA2.
REQ-023 Length 07, cmd 03 with target 48'h112233445566 -> yaw_req=1, yaw_target=48'h112233445566; yaw_ack -> tx_data=8'hA3.
REQ-024 Decoder returns error=1, cmd 16'hFFFF -> tx_data=8'hE2, err_count=1; encrypt_en unchanged.
REQ-025 Length 8'h00 and 8'h81 -> 8'hE1 each, err_count=2, no dec_start.
REQ-026 Length 05, only 3 bytes then silence -> after TIMEOUT_CYCLES tx_data=8'hE4; yaw_ack withheld -> 8'hE6, yaw_req=0.
REQ-027 reset_n low during COLLECT and tx_ready held low in RESP -> immediate IDLE, all outputs 0; tx_valid stays high until tx_ready.
